// File: rtl/csa_4_2_row_pipe.sv
// Row of W 4:2 compressors reducing four masked operands to a carry-save pair,
// with a LAT-stage (1 or 2) valid/ready pipeline and a pass-through tag.
module csa_4_2_row_pipe #(
    parameter int W     = 16,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_c,
    input  logic [W-1:0]     in_d,
    input  logic [3:0]       in_zmask,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic [W:0]       out_carry,
    output logic [TAG_W-1:0] out_tag
);

    logic [W-1:0] w_a, w_b, w_c, w_d;
    logic [W-1:0] w_s1, w_co;

    assign w_a = in_zmask[0] ? '0 : in_a;
    assign w_b = in_zmask[1] ? '0 : in_b;
    assign w_c = in_zmask[2] ? '0 : in_c;
    assign w_d = in_zmask[3] ? '0 : in_d;

    // Level 1: bitwise full adders over a, b, c.
    assign w_s1 = w_a ^ w_b ^ w_c;
    assign w_co = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

    logic [W-1:0]     w_l2_s1, w_l2_co, w_l2_d;
    logic [TAG_W-1:0] w_l2_tag;
    logic             w_l2_valid;

    logic             r_out_valid;
    logic [W:0]       r_out_sum, r_out_carry;
    logic [TAG_W-1:0] r_out_tag;
    logic             w_out_load;

    assign w_out_load = !r_out_valid || out_ready;

    generate
        if (LAT == 1) begin : g_lat1
            assign w_l2_s1    = w_s1;
            assign w_l2_co    = w_co;
            assign w_l2_d     = w_d;
            assign w_l2_tag   = in_tag;
            assign w_l2_valid = in_valid;
            assign in_ready   = w_out_load;
        end else begin : g_lat2
            logic             r_v1;
            logic [W-1:0]     r_s1, r_co, r_d;
            logic [TAG_W-1:0] r_tag;
            logic             w_s1_load;

            // NOTE: in_ready is combinational through w_out_load, so a drain frees a slot the same cycle.
            assign w_s1_load = !r_v1 || w_out_load;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    r_v1  <= 1'b0;
                    r_s1  <= '0;
                    r_co  <= '0;
                    r_d   <= '0;
                    r_tag <= '0;
                end else if (w_s1_load) begin
                    r_v1  <= in_valid;
                    r_s1  <= w_s1;
                    r_co  <= w_co;
                    r_d   <= w_d;
                    r_tag <= in_tag;
                end
            end

            assign w_l2_s1    = r_s1;
            assign w_l2_co    = r_co;
            assign w_l2_d     = r_d;
            assign w_l2_tag   = r_tag;
            assign w_l2_valid = r_v1;
            assign in_ready   = w_s1_load;
        end
    endgenerate

    // Level 2: carry-in of bit i is the level-1 carry of bit i-1.
    logic [W-1:0] w_ci, w_dv, w_cv;

    assign w_ci = {w_l2_co[W-2:0], 1'b0};
    assign w_dv = w_l2_s1 ^ w_l2_d ^ w_ci;
    assign w_cv = (w_l2_s1 & w_l2_d) | (w_l2_s1 & w_ci) | (w_l2_d & w_ci);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= '0;
            r_out_tag   <= '0;
        end else if (w_out_load) begin
            r_out_valid <= w_l2_valid;
            r_out_sum   <= {w_l2_co[W-1], w_dv};
            r_out_carry <= {w_cv, 1'b0};
            r_out_tag   <= w_l2_tag;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_csa_4_2_row_pipe.sv
// Bench for csa_4_2_row_pipe: LAT=1 and LAT=2 instances share operand inputs;
// directed vectors plus a per-instance scoreboard on the carry-save invariant.
module tb_csa_4_2_row_pipe;

    localparam int W     = 16;
    localparam int TAG_W = 4;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    logic [W-1:0]     in_a, in_b, in_c, in_d;
    logic [3:0]       in_zmask;
    logic [TAG_W-1:0] in_tag;

    // Index 0 is the LAT=1 instance, index 1 the LAT=2 instance.
    logic             in_valid_s  [2];
    logic             in_ready_s  [2];
    logic             out_valid_s [2];
    logic             out_ready_s [2];
    logic [W:0]       out_sum_s   [2];
    logic [W:0]       out_carry_s [2];
    logic [TAG_W-1:0] out_tag_s   [2];
    int               depth       [2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [W+1:0]     total;
        logic [TAG_W-1:0] tag;
    } exp_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, c, d, input logic [3:0] zm);
        logic [W+1:0] t;
        t = '0;
        if (!zm[0]) t = t + (W+2)'(a);
        if (!zm[1]) t = t + (W+2)'(b);
        if (!zm[2]) t = t + (W+2)'(c);
        if (!zm[3]) t = t + (W+2)'(d);
        return t;
    endfunction

    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            csa_4_2_row_pipe #(.W(W), .LAT(k + 1), .TAG_W(TAG_W)) u_dut (
                .sys_clk   (sys_clk),
                .sys_rst   (sys_rst),
                .in_valid  (in_valid_s[k]),
                .in_ready  (in_ready_s[k]),
                .in_a      (in_a),
                .in_b      (in_b),
                .in_c      (in_c),
                .in_d      (in_d),
                .in_zmask  (in_zmask),
                .in_tag    (in_tag),
                .out_valid (out_valid_s[k]),
                .out_ready (out_ready_s[k]),
                .out_sum   (out_sum_s[k]),
                .out_carry (out_carry_s[k]),
                .out_tag   (out_tag_s[k])
            );

            exp_t             q[$];
            exp_t             e_push, e_pop;
            logic             stall;
            logic [W:0]       p_sum, p_carry;
            logic [TAG_W-1:0] p_tag;

            always @(negedge sys_clk) begin
                if (sys_rst) begin
                    q.delete();
                    stall = 1'b0;
                end else begin
                    if (stall) begin
                        check($sformatf("L%0d_hold_valid", k + 1), out_valid_s[k], 1'b1);
                        check($sformatf("L%0d_hold_sum", k + 1), out_sum_s[k], p_sum);
                        check($sformatf("L%0d_hold_carry", k + 1), out_carry_s[k], p_carry);
                        check($sformatf("L%0d_hold_tag", k + 1), out_tag_s[k], p_tag);
                    end
                    if (in_valid_s[k] && in_ready_s[k]) begin
                        e_push.total = model(in_a, in_b, in_c, in_d, in_zmask);
                        e_push.tag   = in_tag;
                        q.push_back(e_push);
                    end
                    if (out_valid_s[k] && out_ready_s[k]) begin
                        check($sformatf("L%0d_unexpected_result", k + 1), q.size() == 0, 1'b0);
                        if (q.size() != 0) begin
                            e_pop = q.pop_front();
                            check($sformatf("L%0d_total", k + 1),
                                  {1'b0, out_sum_s[k]} + {1'b0, out_carry_s[k]}, e_pop.total);
                            check($sformatf("L%0d_tag", k + 1), out_tag_s[k], e_pop.tag);
                        end
                    end
                    stall   = out_valid_s[k] && !out_ready_s[k];
                    p_sum   = out_sum_s[k];
                    p_carry = out_carry_s[k];
                    p_tag   = out_tag_s[k];
                end
                depth[k] = q.size();
            end
        end
    endgenerate

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] a, b, c, d, input logic [3:0] zm,
                           input logic [TAG_W-1:0] tag);
        in_a = a; in_b = b; in_c = c; in_d = d; in_zmask = zm; in_tag = tag;
    endtask

    task automatic check_reset_state(input string name);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_L%0d_valid", name, k + 1), out_valid_s[k], 1'b0);
            check($sformatf("%s_L%0d_sum", name, k + 1), out_sum_s[k], '0);
            check($sformatf("%s_L%0d_carry", name, k + 1), out_carry_s[k], '0);
            check($sformatf("%s_L%0d_tag", name, k + 1), out_tag_s[k], '0);
            check($sformatf("%s_L%0d_in_ready", name, k + 1), in_ready_s[k], 1'b1);
        end
    endtask

    // One set into both empty pipes; checks exact latency and both output vectors.
    task automatic run_single(input string name, input logic [W-1:0] a, b, c, d,
                              input logic [3:0] zm, input logic [TAG_W-1:0] tag,
                              input logic [W:0] exp_sum, exp_carry);
        set_ops(a, b, c, d, zm, tag);
        for (int k = 0; k < 2; k++) begin
            in_valid_s[k]  = 1'b1;
            out_ready_s[k] = 1'b1;
        end
        step();
        for (int k = 0; k < 2; k++) in_valid_s[k] = 1'b0;
        check({name, "_L1_valid"}, out_valid_s[0], 1'b1);
        check({name, "_L1_sum"}, out_sum_s[0], exp_sum);
        check({name, "_L1_carry"}, out_carry_s[0], exp_carry);
        check({name, "_L1_tag"}, out_tag_s[0], tag);
        check({name, "_L2_early_valid"}, out_valid_s[1], 1'b0);
        step();
        check({name, "_L2_valid"}, out_valid_s[1], 1'b1);
        check({name, "_L2_sum"}, out_sum_s[1], exp_sum);
        check({name, "_L2_carry"}, out_carry_s[1], exp_carry);
        check({name, "_L2_tag"}, out_tag_s[1], tag);
        check({name, "_L1_after_valid"}, out_valid_s[0], 1'b0);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
        end
        repeat (4) step();
        for (int k = 0; k < 2; k++)
            check($sformatf("%s_L%0d_pending", name, k + 1), depth[k], 0);
    endtask

    initial begin
        sys_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
        end
        set_ops('0, '0, '0, '0, 4'h0, '0);
        step();
        step();
        check_reset_state("reset");
        sys_rst = 1'b0;

        // Directed arithmetic and masking at both latencies.
        run_single("basic",    16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'b0000, 4'h5, 17'h00002, 17'h00002);
        run_single("max",      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0000, 4'h7, 17'h1FFFE, 17'h1FFFE);
        run_single("mask_a",   16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0001, 4'h8, 17'h10001, 17'h1FFFC);
        run_single("mask_all", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b1111, 4'h9, 17'h00000, 17'h00000);
        run_single("mask_bc",  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0110, 4'hA, 17'h00000, 17'h1FFFE);
        run_single("spread",   16'h0001, 16'h0002, 16'h0004, 16'h0008, 4'b0000, 4'h3, 17'h0000F, 17'h00000);
        run_single("mask_d",   16'h0001, 16'h0002, 16'h0004, 16'h0008, 4'b1000, 4'h4, 17'h00007, 17'h00000);

        // Full-rate streaming: ready must never drop.
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 2; k++)
                check($sformatf("stream_L%0d_in_ready", k + 1), in_ready_s[k], 1'b1);
            set_ops(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    4'($urandom), TAG_W'($urandom));
            for (int k = 0; k < 2; k++) in_valid_s[k] = 1'b1;
            step();
        end
        drain("stream");

        // Backpressure on the LAT=2 instance.
        in_valid_s[0]  = 1'b0;
        out_ready_s[1] = 1'b0;
        set_ops(16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'b0000, 4'h1);
        in_valid_s[1] = 1'b1;
        check("bp_ready_set1", in_ready_s[1], 1'b1);
        step();
        set_ops(16'h0001, 16'h0002, 16'h0004, 16'h0008, 4'b0000, 4'h2);
        check("bp_ready_set2", in_ready_s[1], 1'b1);
        step();
        set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0001, 4'h3);
        for (int i = 0; i < 3; i++) begin
            check("bp_full_ready", in_ready_s[1], 1'b0);
            check("bp_frozen_valid", out_valid_s[1], 1'b1);
            check("bp_frozen_sum", out_sum_s[1], 17'h00002);
            check("bp_frozen_tag", out_tag_s[1], 4'h1);
            step();
        end
        out_ready_s[1] = 1'b1;
        #1;
        check("bp_release_ready", in_ready_s[1], 1'b1);
        step();
        in_valid_s[1] = 1'b0;
        check("bp_out2_valid", out_valid_s[1], 1'b1);
        check("bp_out2_tag", out_tag_s[1], 4'h2);
        check("bp_out2_sum", out_sum_s[1], 17'h0000F);
        step();
        check("bp_out3_valid", out_valid_s[1], 1'b1);
        check("bp_out3_tag", out_tag_s[1], 4'h3);
        check("bp_out3_carry", out_carry_s[1], 17'h1FFFC);
        step();
        check("bp_empty_valid", out_valid_s[1], 1'b0);
        drain("bp");

        // Random valid/ready toggling on both instances independently.
        for (int i = 0; i < 600; i++) begin
            set_ops(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    4'($urandom), TAG_W'($urandom));
            for (int k = 0; k < 2; k++) begin
                in_valid_s[k]  = 1'($urandom_range(0, 1));
                out_ready_s[k] = 1'($urandom_range(0, 1));
            end
            step();
        end
        drain("random");

        // Reset with sets in flight; in_valid stays high through reset.
        for (int k = 0; k < 2; k++) begin
            out_ready_s[k] = 1'b0;
            in_valid_s[k]  = 1'b1;
        end
        set_ops(16'h1234, 16'h0F0F, 16'h00FF, 16'h8000, 4'b0000, 4'h9);
        step();
        set_ops(16'hFFFF, 16'h0001, 16'h0000, 16'h7777, 4'b0100, 4'hA);
        step();
        check("midrst_L2_full", in_ready_s[1], 1'b0);
        sys_rst = 1'b1;
        set_ops(16'hAAAA, 16'h5555, 16'h3333, 16'hCCCC, 4'b0000, 4'hB);
        step();
        sys_rst = 1'b0;
        for (int k = 0; k < 2; k++) in_valid_s[k] = 1'b0;
        #1;
        check_reset_state("midrst");
        run_single("post_rst", 16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'b0000, 4'h6, 17'h00002, 17'h00002);
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
